pic_bus_interface: RTL and testbench

// - Parametrised, clocked successor to the combinational PIC data bus buffer.
// - Samples CPU write cycles (ICW/OCW) into a command FIFO tagged with A0.
// - Drives status or vector data onto the tri-state bus for RD and INTA cycles

---
 rtl/pic_bus_interface.sv | 93 +++++++++
 tb/tb_pic_bus_interface.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pic_bus_interface.sv
// pic_bus_interface: clocked PIC data bus buffer with an A0-tagged command FIFO and registered read drive.
// Define BUS_TURNAROUND_EN to add one guard cycle after the bus is released.
module pic_bus_interface #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    input  logic                  cs_n,
    input  logic                  wr_n,
    input  logic                  rd_n,
    input  logic                  a0,
    input  logic                  inta_n,
    input  logic [DATA_WIDTH-1:0] status_data,
    input  logic [DATA_WIDTH-1:0] vector_data,
    output logic [DATA_WIDTH:0]   cmd_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  overflow,
    input  logic                  overflow_clr
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   hold;
    logic [DATA_WIDTH-1:0] drive_reg;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic wr_q, drive_en, guard, pend;
    logic wr_act, rd_req, push_req, push, pop, full, drop, wr_en;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // wr_q holds the previous strobe state active-low, so reset leaves it inactive
    assign wr_act    = !cs_n && !wr_n && inta_n;
    assign rd_req    = (!cs_n && !rd_n && wr_n) || !inta_n;
    assign push_req  = (!wr_q && !wr_act) || pend;
    assign push      = push_req && !guard;
    assign cmd_valid = fifo_count != '0;
    assign full      = fifo_count == FULL;
    assign pop       = cmd_valid && cmd_ready;
    assign drop      = push && full && !pop;
    assign wr_en     = push && (!full || pop);
    assign cmd_data  = cmd_valid ? mem[rd_ptr] : '0;
    assign data_bus  = drive_en ? drive_reg : {DATA_WIDTH{1'bz}};

`ifdef BUS_TURNAROUND_EN
    // guard is high for the cycle right after drive_en falls; a push there waits one cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            guard <= 1'b0;
            pend  <= 1'b0;
        end else begin
            guard <= drive_en && !rd_req;
            pend  <= push_req && guard;
        end
    end
`else
    assign guard = 1'b0;
    assign pend  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q       <= 1'b1;
            hold       <= '0;
            drive_en   <= 1'b0;
            drive_reg  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_q       <= !wr_act;
            hold       <= wr_act ? {a0, data_bus} : hold;
            drive_en   <= rd_req && !guard;
            drive_reg  <= rd_req ? (!inta_n ? vector_data : status_data) : drive_reg;
            wr_ptr     <= wr_en ? nxt(wr_ptr) : wr_ptr;
            rd_ptr     <= pop ? nxt(rd_ptr) : rd_ptr;
            fifo_count <= fifo_count + CNT_W'(wr_en) - CNT_W'(pop);
            overflow   <= drop || (overflow && !overflow_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= hold;
    end
endmodule

// File: tb/tb_pic_bus_interface.sv
// tb_pic_bus_interface: directed vector table plus hand sequences for pic_bus_interface.
// A pull-up on data_bus makes a released bus read as 8'hFF.
module tb_pic_bus_interface;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, cs_n, wr_n, rd_n, a0, inta_n, cmd_ready, overflow_clr, tb_oe;
    logic [7:0] status_data, vector_data, tb_drv;
    wire  [7:0] data_bus;
    logic [8:0] cmd_data;
    logic       cmd_valid, overflow;
    logic [2:0] fifo_count;
    int passed = 0, total = 0;

    assign data_bus = tb_oe ? tb_drv : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data_bus[i]);
    end

    pic_bus_interface dut (
        .clk(clk), .reset_n(reset_n), .data_bus(data_bus), .cs_n(cs_n), .wr_n(wr_n),
        .rd_n(rd_n), .a0(a0), .inta_n(inta_n), .status_data(status_data),
        .vector_data(vector_data), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .fifo_count(fifo_count), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    typedef struct packed {
        logic [4:0] ctl;  // {cs_n, wr_n, rd_n, inta_n, a0}
        logic [7:0] d;
        logic       rdy;
        logic [2:0] cnt;
        logic       vld;
        logic [8:0] cmd;
        logic [7:0] bus;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic [4:0] ctl, input logic [7:0] d, input logic rdy,
                               input logic [2:0] cnt, input logic vld, input logic [8:0] cmd,
                               input logic [7:0] bus);
        return vec_t'{ctl, d, rdy, cnt, vld, cmd, bus};
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle();
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; inta_n = 1'b1; cmd_ready = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic wr_start(input logic a, input logic [7:0] d);
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; tb_drv = d; tb_oe = 1'b1;
    endtask

    task automatic write(input logic a, input logic [7:0] d);
        wr_start(a, d);
        cyc();
        idle();
        cyc();
    endtask

    initial begin
        reset_n = 1'b0; a0 = 1'b0; tb_drv = 8'h00; overflow_clr = 1'b0;
        status_data = 8'hA5; vector_data = 8'h48;
        idle();
        cyc(2);
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_cmd", cmd_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_bus", data_bus, 8'hFF);
        reset_n = 1'b1;
        cyc();

        // 3-cycle write, single push, RD drive/release, collisions, INTA, empty push+pop
        vt.push_back(v(5'b00110, 8'h13, 0, 0, 0, 9'h000, 8'h13));
        vt.push_back(v(5'b00110, 8'h13, 0, 0, 0, 9'h000, 8'h13));
        vt.push_back(v(5'b00110, 8'h13, 0, 0, 0, 9'h000, 8'h13));
        vt.push_back(v(5'b11110, 8'h00, 0, 1, 1, 9'h013, 8'hFF));
        vt.push_back(v(5'b11110, 8'h00, 0, 1, 1, 9'h013, 8'hFF));
        vt.push_back(v(5'b11110, 8'h00, 1, 0, 0, 9'h000, 8'hFF));
        vt.push_back(v(5'b01010, 8'h00, 0, 0, 0, 9'h000, 8'hA5));
        vt.push_back(v(5'b01010, 8'h00, 0, 0, 0, 9'h000, 8'hA5));
        vt.push_back(v(5'b11110, 8'h00, 0, 0, 0, 9'h000, 8'hFF));
        vt.push_back(v(5'b11110, 8'h00, 0, 0, 0, 9'h000, 8'hFF));
        vt.push_back(v(5'b00011, 8'h22, 0, 0, 0, 9'h000, 8'h22));
        vt.push_back(v(5'b11110, 8'h00, 0, 1, 1, 9'h122, 8'hFF));
        vt.push_back(v(5'b11110, 8'h00, 1, 0, 0, 9'h000, 8'hFF));
        vt.push_back(v(5'b00100, 8'h33, 0, 0, 0, 9'h000, 8'h48));
        vt.push_back(v(5'b11110, 8'h00, 0, 0, 0, 9'h000, 8'hFF));
        vt.push_back(v(5'b11110, 8'h00, 0, 0, 0, 9'h000, 8'hFF));
        vt.push_back(v(5'b01000, 8'h00, 0, 0, 0, 9'h000, 8'h48));
        vt.push_back(v(5'b11110, 8'h00, 0, 0, 0, 9'h000, 8'hFF));
        vt.push_back(v(5'b11110, 8'h00, 0, 0, 0, 9'h000, 8'hFF));
        vt.push_back(v(5'b00110, 8'h44, 1, 0, 0, 9'h000, 8'h44));
        vt.push_back(v(5'b11110, 8'h00, 1, 1, 1, 9'h044, 8'hFF));
        vt.push_back(v(5'b11110, 8'h00, 1, 0, 0, 9'h000, 8'hFF));
        vt.push_back(v(5'b11110, 8'h00, 0, 0, 0, 9'h000, 8'hFF));

        foreach (vt[k]) begin
            {cs_n, wr_n, rd_n, inta_n, a0} = vt[k].ctl;
            tb_drv = vt[k].d;
            tb_oe = !vt[k].ctl[3] && vt[k].ctl[1];
            cmd_ready = vt[k].rdy;
            cyc();
            chk($sformatf("vec%0d_count", k), fifo_count, vt[k].cnt);
            chk($sformatf("vec%0d_valid", k), cmd_valid, vt[k].vld);
            chk($sformatf("vec%0d_cmd", k), cmd_data, vt[k].cmd);
            chk($sformatf("vec%0d_bus", k), data_bus, vt[k].bus);
        end
        idle();
        cyc(2);

        // fill, overflow on fifth write, drain in order, clear sticky flag
        for (int i = 0; i < 4; i++) write(1'b0, 8'h11 + 8'(i));
        chk("fill_count", fifo_count, 4);
        chk("fill_ovf", overflow, 0);
        write(1'b0, 8'h15);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", cmd_data, 9'h011);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), cmd_data, 9'h011 + 9'(i));
            cyc();
        end
        cmd_ready = 1'b0;
        chk("drain_count", fifo_count, 0);
        chk("ovf_sticky", overflow, 1);
        overflow_clr = 1'b1;
        cyc();
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // full FIFO, push and pop on the same edge
        for (int i = 0; i < 4; i++) write(1'b1, 8'h21 + 8'(i));
        wr_start(1'b1, 8'h25);
        cyc();
        idle();
        cmd_ready = 1'b1;
        cyc();
        cmd_ready = 1'b0;
        chk("pp_count", fifo_count, 4);
        chk("pp_ovf", overflow, 0);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_order%0d", i), cmd_data, 9'h122 + 9'(i));
            cyc();
        end
        idle();
        cyc(2);

        // INTA drive latency, release, then an immediate RD
        inta_n = 1'b0;
        chk("inta_pre", data_bus, 8'hFF);
        cyc();
        chk("inta_drive", data_bus, 8'h48);
        inta_n = 1'b1;
        cyc();
        chk("inta_release", data_bus, 8'hFF);
        cs_n = 1'b0; rd_n = 1'b0;
        cyc();
`ifdef BUS_TURNAROUND_EN
        chk("ta_rd_first", data_bus, 8'hFF);
`else
        chk("ta_rd_first", data_bus, 8'hA5);
`endif
        cyc();
        chk("ta_rd_second", data_bus, 8'hA5);
        idle();
        cyc(3);

        // write strobe ending right after the bus is released
        cs_n = 1'b0; rd_n = 1'b0;
        cyc();
        chk("tw_rd", data_bus, 8'hA5);
        rd_n = 1'b1; wr_n = 1'b0; a0 = 1'b0;
        cyc();
        chk("tw_released", data_bus, 8'hFF);
        idle();
        cyc();
`ifdef BUS_TURNAROUND_EN
        chk("tw_push_edge", fifo_count, 0);
`else
        chk("tw_push_edge", fifo_count, 1);
`endif
        cyc();
        chk("tw_count", fifo_count, 1);
        chk("tw_cmd", cmd_data, 9'h0A5);
        cmd_ready = 1'b1;
        cyc();
        idle();
        chk("tw_popped", fifo_count, 0);
        cyc(2);

        // reset mid-write and mid-INTA
        write(1'b0, 8'h66);
        chk("rw_pre", fifo_count, 1);
        wr_start(1'b0, 8'h77);
        cyc();
        reset_n = 1'b0;
        cyc();
        chk("rw_count", fifo_count, 0);
        chk("rw_valid", cmd_valid, 0);
        chk("rw_cmd", cmd_data, 0);
        idle();
        reset_n = 1'b1;
        cyc(2);
        chk("rw_nopush", fifo_count, 0);
        inta_n = 1'b0;
        cyc();
        chk("ri_drive", data_bus, 8'h48);
        reset_n = 1'b0;
        cyc();
        chk("ri_bus", data_bus, 8'hFF);
        inta_n = 1'b1;
        reset_n = 1'b1;
        cyc();
        chk("ri_after", data_bus, 8'hFF);
        chk("ri_count", fifo_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
